// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: core register map,
// FSM state encoding and the counter-word packing helpers.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C,
        ST_WR_K,
        ST_WR_START,
        ST_WAIT_LOCK,
        ST_FINISH
    } state_t;

    function automatic logic [31:0] pack_mn(input logic [7:0] hi, input logic [7:0] lo,
                                            input logic byp, input logic odd);
        return {14'b0, odd, byp, hi, lo};
    endfunction

    function automatic logic [31:0] pack_c(input logic [4:0] sel, input logic [7:0] hi,
                                           input logic [7:0] lo, input logic byp,
                                           input logic odd);
        return {9'b0, sel, odd, byp, hi, lo};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (PLL lock indicator).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM master that programs a counter set into the PLL reconfig core,
// triggers reconfiguration and waits for a stable lock or a timeout.
//
//  state        | meaning
//  -------------+------------------------------------------------------------
//  ST_INIT      | write mode register (waitrequest mode), then go idle
//  ST_IDLE      | req_ready=1, accept and latch a counter-set request
//  ST_WR_N      | N counter write in flight
//  ST_WR_M      | M counter write in flight
//  ST_WR_C      | C0 counter write in flight
//  ST_WR_K      | fractional K write in flight (only when USE_FRAC)
//  ST_WR_START  | start write in flight; core stalls it through reconfig
//  ST_WAIT_LOCK | count lock-stable and timeout cycles
//  ST_FINISH    | done pulse, timeout qualifies it
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 1_000_000,
    parameter int LOCK_STABLE  = 64,
    parameter int USE_FRAC     = 1
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_m_hi,
    input  logic [7:0]  req_m_lo,
    input  logic [7:0]  req_n_hi,
    input  logic [7:0]  req_n_lo,
    input  logic [7:0]  req_c_hi,
    input  logic [7:0]  req_c_lo,
    input  logic [2:0]  req_byp,
    input  logic [2:0]  req_odd,
    input  logic [31:0] req_frac_k,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE);
    localparam logic [STB_W-1:0] STB_MAX  = '1;

    state_t           state;
    logic [31:0]      m_word;
    logic [31:0]      c_word;
    logic [31:0]      k_word;
    logic [TMO_W-1:0] tmo;
    logic [STB_W-1:0] stable;
    logic             locked_s;

    assign mgmt_read = 1'b0;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Each write state is entered with its transfer already on the bus, so a
    // completion loads the next transfer directly and writes run back to back.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            timeout        <= 1'b0;
            req_ready      <= 1'b0;
            tmo            <= '0;
            stable         <= '0;
            m_word         <= '0;
            c_word         <= '0;
            k_word         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!mgmt_write) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= '0;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        m_word         <= pack_mn(req_m_hi, req_m_lo, req_byp[0], req_odd[0]);
                        c_word         <= pack_c(5'd0, req_c_hi, req_c_lo, req_byp[2], req_odd[2]);
                        k_word         <= req_frac_k;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_N;
                        mgmt_writedata <= pack_mn(req_n_hi, req_n_lo, req_byp[1], req_odd[1]);
                        state          <= ST_WR_N;
                        busy           <= 1'b1;
                        req_ready      <= 1'b0;
                    end
                end
                ST_WR_N: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_address   <= ADDR_M;
                        mgmt_writedata <= m_word;
                        state          <= ST_WR_M;
                    end
                end
                ST_WR_M: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_address   <= ADDR_C;
                        mgmt_writedata <= c_word;
                        state          <= ST_WR_C;
                    end
                end
                ST_WR_C: begin
                    if (!mgmt_waitrequest) begin
                        if (USE_FRAC != 0) begin
                            mgmt_address   <= ADDR_K;
                            mgmt_writedata <= k_word;
                            state          <= ST_WR_K;
                        end else begin
                            mgmt_address   <= ADDR_START;
                            mgmt_writedata <= 32'd1;
                            state          <= ST_WR_START;
                        end
                    end
                end
                ST_WR_K: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_address   <= ADDR_START;
                        mgmt_writedata <= 32'd1;
                        state          <= ST_WR_START;
                    end
                end
                ST_WR_START: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_write     <= 1'b0;
                        mgmt_address   <= '0;
                        mgmt_writedata <= '0;
                        tmo            <= '0;
                        stable         <= '0;
                        state          <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins when both limits land together.
                    if (stable == STB_DONE) begin
                        state   <= ST_FINISH;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (tmo == TMO_LAST) begin
                        state   <= ST_FINISH;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                    if (tmo != TMO_MAX) begin
                        tmo <= tmo + 1'b1;
                    end
                    if (!locked_s) begin
                        stable <= '0;
                    end else if (stable != STB_MAX) begin
                        stable <= stable + 1'b1;
                    end
                end
                ST_FINISH: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state      <= ST_INIT;
                    mgmt_write <= 1'b0;
                    busy       <= 1'b1;
                    req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Bench for pll_reconfig_sequencer: reconfig-core model with stalls and a write
// log, scoreboard of expected Avalon writes, and lock/timeout scenarios.
module tb_pll_reconfig_sequencer;

    localparam int LOCK_TIMEOUT = 200;
    localparam int LOCK_STABLE  = 64;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        refclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_m_hi = '0, req_m_lo = '0, req_n_hi = '0, req_n_lo = '0;
    logic [7:0]  req_c_hi = '0, req_c_lo = '0;
    logic [2:0]  req_byp = '0, req_odd = '0;
    logic [31:0] req_frac_k = '0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic        busy, done, timeout;

    int vectors = 0;
    int miscompares = 0;

    // core model / monitor state
    wr_t  wlog[$];
    int   cyc = 0;
    int   start_cnt = 0, start_cyc = 0;
    int   done_cnt = 0, done_cyc = 0;
    logic done_tmo = 1'b0;
    int   done_flag_errs = 0;
    int   hold_errs = 0;
    int   m_stalls = 0;
    logic rbit = 1'b0;
    logic prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic rand_wait = 1'b0;
    logic stall_m = 1'b0;
    logic m_hit;

    // scoreboard state
    wr_t exp_q[$];
    int  rd_ptr = 0;
    int  start_base = 0, done_base = 0, accept_cyc = 0;

    always #5 refclk = ~refclk;

    pll_reconfig_sequencer #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .USE_FRAC     (1)
    ) dut (
        .refclk           (refclk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_m_hi         (req_m_hi),
        .req_m_lo         (req_m_lo),
        .req_n_hi         (req_n_hi),
        .req_n_lo         (req_n_lo),
        .req_c_hi         (req_c_hi),
        .req_c_lo         (req_c_lo),
        .req_byp          (req_byp),
        .req_odd          (req_odd),
        .req_frac_k       (req_frac_k),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .busy             (busy),
        .done             (done),
        .timeout          (timeout)
    );

    assign m_hit = stall_m && mgmt_write && (mgmt_address == 6'd4) && (m_stalls < 7);

    always @(posedge refclk) begin
        cyc  <= cyc + 1;
        rbit <= ($urandom_range(0, 3) == 0);
        if (mgmt_write && !mgmt_waitrequest) begin
            wlog.push_back(wr_t'({mgmt_address, mgmt_writedata}));
            if (mgmt_address == 6'd2) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc + 1;
            end
        end
    end

    always @(negedge refclk) begin
        if (prev_stall && (mgmt_write !== 1'b1 || mgmt_address !== prev_addr ||
                           mgmt_writedata !== prev_data))
            hold_errs <= hold_errs + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_tmo <= timeout;
            if (req_ready || !busy) done_flag_errs <= done_flag_errs + 1;
        end
        if (!stall_m) m_stalls <= 0;
        else if (m_hit) m_stalls <= m_stalls + 1;
        mgmt_waitrequest <= m_hit || (rand_wait && rbit);
        prev_stall       <= mgmt_write && (m_hit || (rand_wait && rbit));
        prev_addr        <= mgmt_address;
        prev_data        <= mgmt_writedata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic push_expected(input logic [7:0] m_hi, input logic [7:0] m_lo,
                                 input logic [7:0] n_hi, input logic [7:0] n_lo,
                                 input logic [7:0] c_hi, input logic [7:0] c_lo,
                                 input logic [2:0] byp, input logic [2:0] odd,
                                 input logic [31:0] k);
        exp_q.push_back(wr_t'({6'd3, 14'b0, odd[1], byp[1], n_hi, n_lo}));
        exp_q.push_back(wr_t'({6'd4, 14'b0, odd[0], byp[0], m_hi, m_lo}));
        exp_q.push_back(wr_t'({6'd5, 9'b0, 5'd0, odd[2], byp[2], c_hi, c_lo}));
        exp_q.push_back(wr_t'({6'd7, k}));
        exp_q.push_back(wr_t'({6'd2, 32'd1}));
    endtask

    task automatic send_req(input logic [7:0] m_hi, input logic [7:0] m_lo,
                            input logic [7:0] n_hi, input logic [7:0] n_lo,
                            input logic [7:0] c_hi, input logic [7:0] c_lo,
                            input logic [2:0] byp, input logic [2:0] odd,
                            input logic [31:0] k, output logic ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        ok = (req_ready === 1'b1);
        {req_m_hi, req_m_lo, req_n_hi, req_n_lo} = {m_hi, m_lo, n_hi, n_lo};
        {req_c_hi, req_c_lo, req_byp, req_odd, req_frac_k} = {c_hi, c_lo, byp, odd, k};
        req_valid  = 1'b1;
        start_base = start_cnt;
        done_base  = done_cnt;
        tick(1);
        accept_cyc = cyc;
        req_valid  = 1'b0;
        // scramble the request bus; the DUT must work from its latched copy
        {req_m_hi, req_m_lo, req_n_hi, req_n_lo} = $urandom;
        {req_c_hi, req_c_lo} = 16'($urandom);
        req_byp    = 3'($urandom);
        req_odd    = 3'($urandom);
        req_frac_k = $urandom;
    endtask

    task automatic wait_start(input int budget, output logic ok);
        int n = 0;
        while (start_cnt == start_base && n < budget) begin
            tick(1);
            n++;
        end
        ok = (start_cnt != start_base);
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            tick(1);
            n++;
        end
        ok = (done_cnt != done_base);
    endtask

    task automatic test_reset();
        int  n = 0;
        wr_t g;
        rst_n = 1'b0;
        tick(3);
        vectors++;
        if ({mgmt_write, mgmt_read, busy, done, timeout, req_ready} !== 6'b001000) begin
            miscompares++;
            $display("FAIL reset_flags: got w/r/busy/done/tmo/rdy=%b want 001000",
                     {mgmt_write, mgmt_read, busy, done, timeout, req_ready});
        end
        vectors++;
        if (mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr=%0h data=%0h want 0/0", mgmt_address, mgmt_writedata);
        end
        rd_ptr = wlog.size();
        rst_n = 1'b1;
        while (req_ready !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1 || n > 2) begin
            miscompares++;
            $display("FAIL reset_ready: got ready=%b after %0d cycles want 1 within 2", req_ready, n);
        end
        vectors++;
        if (int'(wlog.size()) - rd_ptr != 1) begin
            miscompares++;
            $display("FAIL init_write_count: got %0d want 1", int'(wlog.size()) - rd_ptr);
        end else begin
            g = wlog[rd_ptr];
            vectors++;
            if (g !== wr_t'({6'd0, 32'd0})) begin
                miscompares++;
                $display("FAIL init_write: got addr=%0h data=%0h want 0/0", g.addr, g.data);
            end
        end
        rd_ptr = wlog.size();
    endtask

    task automatic test_basic();
        logic ok;
        wr_t  e, g;
        rand_wait = 1'b0;
        send_req(8'd4, 8'd4, 8'd0, 8'd0, 8'd2, 8'd2, 3'b010, 3'b000, 32'h8000_0000, ok);
        exp_q.push_back(wr_t'({6'd3, 32'h0001_0000}));
        exp_q.push_back(wr_t'({6'd4, 32'h0000_0404}));
        exp_q.push_back(wr_t'({6'd5, 32'h0000_0202}));
        exp_q.push_back(wr_t'({6'd7, 32'h8000_0000}));
        exp_q.push_back(wr_t'({6'd2, 32'h0000_0001}));
        wait_start(50, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_start: got no start write want one within 50 cycles");
        end
        pll_locked = 1'b1;
        vectors++;
        if (start_cyc - accept_cyc != 5) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want 5", start_cyc - accept_cyc);
        end
        vectors++;
        if (int'(wlog.size()) - rd_ptr != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d want %0d", int'(wlog.size()) - rd_ptr, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_ptr < wlog.size()) begin
            e = exp_q.pop_front();
            g = wlog[rd_ptr];
            rd_ptr++;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL basic_write: got %0h=%h want %0h=%h", g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete();
        rd_ptr = wlog.size();
        wait_done(150, ok);
        vectors++;
        if (!ok || done_cyc - start_cyc < LOCK_STABLE + 1 || done_cyc - start_cyc > LOCK_STABLE + 4) begin
            miscompares++;
            $display("FAIL basic_done_time: got seen=%b at %0d want within [%0d,%0d]",
                     ok, done_cyc - start_cyc, LOCK_STABLE + 1, LOCK_STABLE + 4);
        end
        vectors++;
        if (done_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_timeout: got %b want 0", done_tmo);
        end
        vectors++;
        if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after_done: got done/rdy/busy=%b%b%b want 010", done, req_ready, busy);
        end
        pll_locked = 1'b0;
    endtask

    task automatic test_stall();
        logic ok;
        wr_t  e, g;
        stall_m = 1'b1;
        send_req(8'h12, 8'h34, 8'h05, 8'h06, 8'h0a, 8'h0b, 3'b000, 3'b101, 32'h1234_5678, ok);
        push_expected(8'h12, 8'h34, 8'h05, 8'h06, 8'h0a, 8'h0b, 3'b000, 3'b101, 32'h1234_5678);
        wait_start(60, ok);
        vectors++;
        if (!ok || start_cyc - accept_cyc != 12) begin
            miscompares++;
            $display("FAIL stall_latency: got seen=%b lat=%0d want 12", ok, start_cyc - accept_cyc);
        end
        pll_locked = 1'b1;
        vectors++;
        if (m_stalls != 7 || hold_errs != 0) begin
            miscompares++;
            $display("FAIL stall_hold: got stalls=%0d hold_errs=%0d want 7/0", m_stalls, hold_errs);
        end
        vectors++;
        if (int'(wlog.size()) - rd_ptr != exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_write_count: got %0d want %0d", int'(wlog.size()) - rd_ptr, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_ptr < wlog.size()) begin
            e = exp_q.pop_front();
            g = wlog[rd_ptr];
            rd_ptr++;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL stall_write: got %0h=%h want %0h=%h", g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete();
        rd_ptr = wlog.size();
        stall_m = 1'b0;
        wait_done(150, ok);
        vectors++;
        if (!ok || done_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done: got seen=%b timeout=%b want 1/0", ok, done_tmo);
        end
        pll_locked = 1'b0;
    endtask

    task automatic test_timeout();
        logic ok;
        wr_t  e, g;
        rand_wait  = 1'b1;
        pll_locked = 1'b0;
        send_req(8'h20, 8'h1f, 8'h01, 8'h02, 8'h03, 8'h04, 3'b101, 3'b010, 32'h0000_abcd, ok);
        push_expected(8'h20, 8'h1f, 8'h01, 8'h02, 8'h03, 8'h04, 3'b101, 3'b010, 32'h0000_abcd);
        wait_start(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL tmo_start: got no start write want one within 200 cycles");
        end
        while (exp_q.size() > 0 && rd_ptr < wlog.size()) begin
            e = exp_q.pop_front();
            g = wlog[rd_ptr];
            rd_ptr++;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL tmo_write: got %0h=%h want %0h=%h", g.addr, g.data, e.addr, e.data);
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL tmo_write_count: got %0d missing want 0", exp_q.size());
        end
        exp_q.delete();
        rd_ptr = wlog.size();
        wait_done(LOCK_TIMEOUT + 50, ok);
        vectors++;
        if (!ok || done_cyc - start_cyc != LOCK_TIMEOUT) begin
            miscompares++;
            $display("FAIL tmo_done_time: got seen=%b at %0d want %0d", ok, done_cyc - start_cyc, LOCK_TIMEOUT);
        end
        vectors++;
        if (done_tmo !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_flag: got %b want 1", done_tmo);
        end
        tick(3);
        vectors++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_hold: got timeout=%b busy=%b want 1/0", timeout, busy);
        end
        vectors++;
        if (hold_errs != 0 || done_flag_errs != 0) begin
            miscompares++;
            $display("FAIL tmo_protocol: got hold_errs=%0d done_flag_errs=%0d want 0/0", hold_errs, done_flag_errs);
        end
    endtask

    task automatic test_glitch();
        logic ok;
        wr_t  e, g;
        rand_wait = 1'b1;
        send_req(8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 3'b000, 3'b111, 32'h5555_aaaa, ok);
        push_expected(8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 3'b000, 3'b111, 32'h5555_aaaa);
        wait_start(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL glitch_start: got no start write want one within 200 cycles");
        end
        while (exp_q.size() > 0 && rd_ptr < wlog.size()) begin
            e = exp_q.pop_front();
            g = wlog[rd_ptr];
            rd_ptr++;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL glitch_write: got %0h=%h want %0h=%h", g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete();
        rd_ptr = wlog.size();
        pll_locked = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            tick(1);
            pll_locked = (i % 30 != 0);
        end
        tick(1);
        pll_locked = 1'b1;
        vectors++;
        if (done_cnt != done_base) begin
            miscompares++;
            $display("FAIL glitch_early_done: got %0d done pulses want 0", done_cnt - done_base);
        end
        wait_done(150, ok);
        vectors++;
        if (!ok || done_cyc - start_cyc < 90 + LOCK_STABLE + 1 || done_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_done: got seen=%b at %0d timeout=%b want >=%0d timeout=0",
                     ok, done_cyc - start_cyc, done_tmo, 90 + LOCK_STABLE + 1);
        end
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_timeout_out: got %b want 0", timeout);
        end
        pll_locked = 1'b0;
        rand_wait  = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic ok;
        int   n = 0;
        int   base;
        wr_t  e, g;
        send_req(8'h10, 8'h10, 8'h01, 8'h01, 8'h04, 8'h04, 3'b000, 3'b000, 32'h0, ok);
        push_expected(8'h10, 8'h10, 8'h01, 8'h01, 8'h04, 8'h04, 3'b000, 3'b000, 32'h0);
        wait_start(50, ok);
        pll_locked = 1'b1;
        tick(20);
        base  = done_cnt;
        rst_n = 1'b0;
        tick(1);
        vectors++;
        if (mgmt_write !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: got w/busy/rdy/done=%b%b%b%b want 0100",
                     mgmt_write, busy, req_ready, done);
        end
        tick(2);
        exp_q.push_back(wr_t'({6'd0, 32'd0}));
        rst_n = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        vectors++;
        if (int'(wlog.size()) - rd_ptr != exp_q.size()) begin
            miscompares++;
            $display("FAIL abort_write_count: got %0d want %0d", int'(wlog.size()) - rd_ptr, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_ptr < wlog.size()) begin
            e = exp_q.pop_front();
            g = wlog[rd_ptr];
            rd_ptr++;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL abort_write: got %0h=%h want %0h=%h", g.addr, g.data, e.addr, e.data);
            end
        end
        exp_q.delete();
        rd_ptr = wlog.size();
        tick(80);
        vectors++;
        if (done_cnt != base) begin
            miscompares++;
            $display("FAIL abort_stale_done: got %0d pulses want 0", done_cnt - base);
        end
        pll_locked = 1'b0;
        send_req(8'h03, 8'h02, 8'h01, 8'h01, 8'h06, 8'h05, 3'b100, 3'b001, 32'h0000_0010, ok);
        wait_start(50, ok);
        pll_locked = 1'b1;
        wait_done(150, ok);
        vectors++;
        if (!ok || done_cnt != base + 1 || done_tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_new_done: got pulses=%0d timeout=%b want 1/0", done_cnt - base, done_tmo);
        end
        pll_locked = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_glitch();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
